// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//
// Purpose:
//   Re-times the free-running divided clock from the fractional divider into the
//   fast clk_src domain and turns it into single-cycle clock enables.
//   Downstream logic (CPU core, PSG, timers) runs on clk_src and qualifies its
//   work with these enables. The divided clock is never used as a real clock.
//   The block also provides:
//     - a sub-divided enable (ce_div), one pulse per DIV_N rising edges;
//     - a wrapping tick counter of the rising edges;
//     - an optional clock-loss watchdog.
//
// Optional feature:
//   Define CLKEN_WATCHDOG_EN to build the clock-loss watchdog.
//   Without it, clk_alive is a constant 1, including during reset.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on clk_div_in (2..4)
//   DIV_N        ce_div fires on every DIV_N-th rising edge (1..256)
//   CNT_W        width of tick_count
//   WDT_LIMIT    clk_src cycles without an edge before clk_alive drops (2..65535)
//
// Ports:
//   clk_src     in   fast source clock (same clock that feeds the divider)
//   rst_n       in   asynchronous active-low reset
//   clk_div_in  in   divided clock, treated as asynchronous
//   sync_clear  in   synchronous clear of div_phase and tick_count
//   ce_rise     out  one-cycle pulse per synced rising edge of clk_div_in
//   ce_fall     out  one-cycle pulse per synced falling edge of clk_div_in
//   ce_div      out  one-cycle pulse on every DIV_N-th ce_rise
//   div_phase   out  current divide phase, 0..DIV_N-1
//   tick_count  out  rising edges seen, wraps
//   clk_alive   out  high while the divided clock is toggling
// -----------------------------------------------------------------------------
module clk_enable_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_N       = 2,
   parameter int CNT_W       = 16,
   parameter int WDT_LIMIT   = 64
) (
   input  logic             clk_src,
   input  logic             rst_n,
   input  logic             clk_div_in,
   input  logic             sync_clear,
   output logic             ce_rise,
   output logic             ce_fall,
   output logic             ce_div,
   output logic [7:0]       div_phase,
   output logic [CNT_W-1:0] tick_count,
   output logic             clk_alive
);

   // Reject illegal parameter combinations at elaboration time.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DIV_N < 1 || DIV_N > 256 ||
       CNT_W < 1 || WDT_LIMIT < 2 || WDT_LIMIT > 65535) begin : g_param_check
      $error("clk_enable_gen: parameter out of legal range");
   end

   localparam logic [7:0] LAST_PHASE = 8'(DIV_N - 1);

   // ---------------------------------------------------------------------------
   // Synchronizer chain; the last stage is the re-timed level "s".
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
         assign sync_d[gi] = clk_div_in;
      end else begin : g_next
         assign sync_d[gi] = sync_q[gi-1];
      end
   end

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   logic s;
   logic rise_det;
   logic fall_det;

   logic             prev_q, prev_d;
   logic             ce_rise_q, ce_rise_d;
   logic             ce_fall_q, ce_fall_d;
   logic             ce_div_q, ce_div_d;
   logic [7:0]       div_phase_q, div_phase_d;
   logic [CNT_W-1:0] tick_count_q, tick_count_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Edge detection on the synchronized level. These signals are high for
   // the one cycle before the registered enables appear.
   assign rise_det = s & ~prev_q;
   assign fall_det = ~s & prev_q;

   always_comb begin
      prev_d       = s;
      ce_rise_d    = rise_det;
      ce_fall_d    = fall_det;
      ce_div_d     = 1'b0;
      div_phase_d  = div_phase_q;
      tick_count_d = tick_count_q;

      // A clear takes priority over a coincident rise. Both counters restart
      // from 0 and ce_div is suppressed. ce_rise and ce_fall are unaffected.
      if (sync_clear) begin
         div_phase_d  = 8'd0;
         tick_count_d = '0;
      end else if (rise_det) begin
         tick_count_d = tick_count_q + CNT_W'(1);
         if (div_phase_q == LAST_PHASE) begin
            div_phase_d = 8'd0;
            ce_div_d    = 1'b1;
         end else begin
            div_phase_d = div_phase_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         prev_q       <= 1'b0;
         ce_rise_q    <= 1'b0;
         ce_fall_q    <= 1'b0;
         ce_div_q     <= 1'b0;
         div_phase_q  <= 8'd0;
         tick_count_q <= '0;
      end else begin
         prev_q       <= prev_d;
         ce_rise_q    <= ce_rise_d;
         ce_fall_q    <= ce_fall_d;
         ce_div_q     <= ce_div_d;
         div_phase_q  <= div_phase_d;
         tick_count_q <= tick_count_d;
      end
   end

   assign ce_rise    = ce_rise_q;
   assign ce_fall    = ce_fall_q;
   assign ce_div     = ce_div_q;
   assign div_phase  = div_phase_q;
   assign tick_count = tick_count_q;

   // ---------------------------------------------------------------------------
   // Clock-loss watchdog
   // ---------------------------------------------------------------------------
`ifdef CLKEN_WATCHDOG_EN
   localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);

   logic [15:0] wdt_q, wdt_d;
   logic        clk_alive_q, clk_alive_d;

   always_comb begin
      wdt_d       = wdt_q;
      clk_alive_d = clk_alive_q;
      // An edge in the same cycle the limit would be reached wins.
      if (rise_det | fall_det) begin
         wdt_d       = 16'd0;
         clk_alive_d = 1'b1;
      end else begin
         if (wdt_q != WDT_MAX) begin
            wdt_d = wdt_q + 16'd1;
         end
         // Drop clk_alive on the same edge the counter lands on the limit,
         // so it falls exactly WDT_LIMIT cycles after the last edge enable.
         if (wdt_d == WDT_MAX) begin
            clk_alive_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         wdt_q       <= 16'd0;
         clk_alive_q <= 1'b0;
      end else begin
         wdt_q       <= wdt_d;
         clk_alive_q <= clk_alive_d;
      end
   end

   assign clk_alive = clk_alive_q;
`else
   assign clk_alive = 1'b1;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// Testbench for clk_enable_gen: SYNC_STAGES=2, DIV_N=2, CNT_W=4, WDT_LIMIT=64.
// Directed steps. Every check is an immediate assertion with a hand-derived
// expected value. Works with or without CLKEN_WATCHDOG_EN defined.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;

   localparam int CNT_W = 4;

`ifdef CLKEN_WATCHDOG_EN
   localparam logic WDT_ON = 1'b1;
`else
   localparam logic WDT_ON = 1'b0;
`endif
   // Value clk_alive must show after reset and after a clock loss.
   localparam logic ALIVE_IDLE = WDT_ON ? 1'b0 : 1'b1;

   logic             clk_src;
   logic             rst_n;
   logic             clk_div_in;
   logic             sync_clear;
   logic             ce_rise;
   logic             ce_fall;
   logic             ce_div;
   logic [7:0]       div_phase;
   logic [CNT_W-1:0] tick_count;
   logic             clk_alive;

   int n_cmp;
   int n_err;

   // Pulse counters for the free-running sections.
   int nrise;
   int nfall;
   int ndiv;
   int noverlap;
   int nstray_div;

   clk_enable_gen #(
      .SYNC_STAGES(2),
      .DIV_N      (2),
      .CNT_W      (CNT_W),
      .WDT_LIMIT  (64)
   ) dut (
      .clk_src   (clk_src),
      .rst_n     (rst_n),
      .clk_div_in(clk_div_in),
      .sync_clear(sync_clear),
      .ce_rise   (ce_rise),
      .ce_fall   (ce_fall),
      .ce_div    (ce_div),
      .div_phase (div_phase),
      .tick_count(tick_count),
      .clk_alive (clk_alive)
   );

   initial clk_src = 1'b0;
   always #5 clk_src = ~clk_src;

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_src);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle clear with no edge in flight.
   task automatic pulse_clear();
      sync_clear = 1'b1;
      tick(1);
      sync_clear = 1'b0;
   endtask

   // Per-cycle pulse bookkeeping. ce_div must coincide with every even rise.
   task automatic observe();
      if (ce_rise && ce_fall) noverlap++;
      if (ce_fall) nfall++;
      if (ce_rise) begin
         nrise++;
         chk($sformatf("sq_div_at_rise%0d", nrise), {31'd0, ce_div}, {31'd0, (nrise % 2) == 0});
      end else if (ce_div) begin
         nstray_div++;
      end
      if (ce_div) ndiv++;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      nrise      = 0;
      nfall      = 0;
      ndiv       = 0;
      noverlap   = 0;
      nstray_div = 0;
      rst_n      = 1'b0;
      clk_div_in = 1'b0;
      sync_clear = 1'b0;

      // ---- Reset values ----
      tick(2);
      chk("rst_ce_rise", {31'd0, ce_rise}, 32'd0);
      chk("rst_ce_fall", {31'd0, ce_fall}, 32'd0);
      chk("rst_ce_div", {31'd0, ce_div}, 32'd0);
      chk("rst_div_phase", {24'd0, div_phase}, 32'd0);
      chk("rst_tick_count", {28'd0, tick_count}, 32'd0);
      chk("rst_clk_alive", {31'd0, clk_alive}, {31'd0, ALIVE_IDLE});

      rst_n = 1'b1;
      tick(3);
      chk("idle_ce_rise", {31'd0, ce_rise}, 32'd0);

      // ---- First rise: sampled at edge k, visible after edge k+2 ----
      clk_div_in = 1'b1;
      tick(1);                                   // edge k
      chk("lat_k", {31'd0, ce_rise}, 32'd0);
      tick(1);                                   // edge k+1
      chk("lat_k1", {31'd0, ce_rise}, 32'd0);
      tick(1);                                   // edge k+2
      chk("lat_k2_rise", {31'd0, ce_rise}, 32'd1);
      chk("lat_k2_tick", {28'd0, tick_count}, 32'd1);
      chk("lat_k2_phase", {24'd0, div_phase}, 32'd1);
      chk("lat_k2_div", {31'd0, ce_div}, 32'd0);
      tick(1);
      chk("lat_width", {31'd0, ce_rise}, 32'd0);

      // ---- First fall ----
      clk_div_in = 1'b0;
      tick(3);
      chk("fall_ce_fall", {31'd0, ce_fall}, 32'd1);
      chk("fall_ce_rise", {31'd0, ce_rise}, 32'd0);
      tick(1);
      chk("fall_width", {31'd0, ce_fall}, 32'd0);

      // ---- Square wave, period 34, 10 rising edges ----
      pulse_clear();
      chk("sq_pre_phase", {24'd0, div_phase}, 32'd0);
      chk("sq_pre_tick", {28'd0, tick_count}, 32'd0);
      for (int c = 0; c < 340; c++) begin
         clk_div_in = ((c % 34) < 17);
         tick(1);
         observe();
      end
      clk_div_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick(1);
         observe();
      end
      chk("sq_nrise", nrise, 32'd10);
      chk("sq_nfall", nfall, 32'd10);
      chk("sq_ndiv", ndiv, 32'd5);
      chk("sq_overlap", noverlap, 32'd0);
      chk("sq_stray_div", nstray_div, 32'd0);
      chk("sq_tick", {28'd0, tick_count}, 32'd10);
      chk("sq_phase", {24'd0, div_phase}, 32'd0);

      // ---- tick_count wrap with CNT_W=4: 1..15, 0, 1 ----
      pulse_clear();
      for (int i = 0; i < 17; i++) begin
         clk_div_in = 1'b1;
         tick(3);
         chk($sformatf("wrap_rise%0d", i + 1), {31'd0, ce_rise}, 32'd1);
         chk($sformatf("wrap_tick%0d", i + 1), {28'd0, tick_count}, (i + 1) % 16);
         clk_div_in = 1'b0;
         tick(4);
      end
      chk("wrap_final", {28'd0, tick_count}, 32'd1);

      // ---- No activity: no pulses, counters hold ----
      tick(10);
      chk("hold_rise", {31'd0, ce_rise}, 32'd0);
      chk("hold_fall", {31'd0, ce_fall}, 32'd0);
      chk("hold_tick", {28'd0, tick_count}, 32'd1);

      // ---- sync_clear coincident with the 2nd detected rise ----
      pulse_clear();
      clk_div_in = 1'b1;
      tick(3);
      chk("clr_r1_tick", {28'd0, tick_count}, 32'd1);
      chk("clr_r1_phase", {24'd0, div_phase}, 32'd1);
      clk_div_in = 1'b0;
      tick(4);
      clk_div_in = 1'b1;
      tick(2);                    // rise is being detected in this cycle
      sync_clear = 1'b1;
      tick(1);
      sync_clear = 1'b0;
      chk("clr_r2_rise", {31'd0, ce_rise}, 32'd1);
      chk("clr_r2_div", {31'd0, ce_div}, 32'd0);
      chk("clr_r2_phase", {24'd0, div_phase}, 32'd0);
      chk("clr_r2_tick", {28'd0, tick_count}, 32'd0);
      clk_div_in = 1'b0;
      tick(4);
      clk_div_in = 1'b1;
      tick(3);
      chk("clr_r3_tick", {28'd0, tick_count}, 32'd1);
      chk("clr_r3_phase", {24'd0, div_phase}, 32'd1);
      chk("clr_r3_div", {31'd0, ce_div}, 32'd0);

      // ---- Watchdog: toggle, lose the clock, restart ----
      clk_div_in = 1'b0;
      tick(3);                    // edge E: last detected edge (fall)
      chk("wdt_fall", {31'd0, ce_fall}, 32'd1);
      chk("wdt_alive_toggling", {31'd0, clk_alive}, 32'd1);
      tick(63);
      chk("wdt_alive_e63", {31'd0, clk_alive}, 32'd1);
      tick(1);
      chk("wdt_alive_e64", {31'd0, clk_alive}, {31'd0, ALIVE_IDLE});
      tick(20);
      chk("wdt_alive_held", {31'd0, clk_alive}, {31'd0, ALIVE_IDLE});
      clk_div_in = 1'b1;
      tick(2);
      chk("wdt_alive_pre", {31'd0, clk_alive}, {31'd0, ALIVE_IDLE});
      tick(1);
      chk("wdt_restart_rise", {31'd0, ce_rise}, 32'd1);
      chk("wdt_alive_restart", {31'd0, clk_alive}, 32'd1);

      // ---- Asynchronous reset during ce_rise ----
      clk_div_in = 1'b0;
      tick(4);
      clk_div_in = 1'b1;
      tick(3);
      chk("ar_pre_rise", {31'd0, ce_rise}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;                         // still mid-cycle: no clock edge yet
      chk("ar_rise", {31'd0, ce_rise}, 32'd0);
      chk("ar_fall", {31'd0, ce_fall}, 32'd0);
      chk("ar_div", {31'd0, ce_div}, 32'd0);
      chk("ar_phase", {24'd0, div_phase}, 32'd0);
      chk("ar_tick", {28'd0, tick_count}, 32'd0);
      chk("ar_alive", {31'd0, clk_alive}, {31'd0, ALIVE_IDLE});
      tick(2);
      rst_n = 1'b1;               // input still high
      tick(1);
      chk("ar_rel_e1", {31'd0, ce_rise}, 32'd0);
      tick(1);
      chk("ar_rel_e2", {31'd0, ce_rise}, 32'd0);
      tick(1);
      chk("ar_rel_e3_rise", {31'd0, ce_rise}, 32'd1);
      chk("ar_rel_e3_tick", {28'd0, tick_count}, 32'd1);
      tick(1);
      chk("ar_rel_width", {31'd0, ce_rise}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
